// File: rtl/instr_fetch.sv
// RV32I instruction fetch: owns the fetch PC, handshakes with instruction memory
// (any number of wait states), and buffers up to two {instr, pc} entries for decode.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        PCSrc,
  input  logic [31:0] PCTarget,
  input  logic        Stall,
  output logic        IMemReq,
  output logic [31:0] IMemAddr,
  input  logic        IMemAck,
  input  logic [31:0] IMemRData,
  output logic [31:0] Instr,
  output logic [31:0] PC,
  output logic [31:0] PCPlus4,
  output logic        InstrValid
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DROP} state_t;

  state_t      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] drop_addr_q, drop_addr_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] instr0_q, instr0_d, pc0_q, pc0_d;
  logic [31:0] instr1_q, instr1_d, pc1_q, pc1_d;

  logic [31:0] target;
  logic        acc;
  logic        deq;

  assign target = PCTarget & 32'hFFFF_FFFC;

  always_comb begin
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    drop_addr_d = drop_addr_q;
    cnt_d       = cnt_q;
    instr0_d    = instr0_q;
    pc0_d       = pc0_q;
    instr1_d    = instr1_q;
    pc1_d       = pc1_q;
    IMemReq     = 1'b0;
    IMemAddr    = fetch_pc_q;

    case (state_q)
      S_IDLE:  IMemReq = (cnt_q != 2'd2) && !PCSrc;
      S_WAIT:  IMemReq = 1'b1;
      S_DROP: begin
        IMemReq  = 1'b1;
        IMemAddr = drop_addr_q;
      end
      default: IMemReq = 1'b0;
    endcase
    if (reset) IMemReq = 1'b0;

    // Data returned during a redirect, or for a stale request, is never enqueued.
    acc = IMemReq && IMemAck && (state_q != S_DROP) && !PCSrc;
    deq = (cnt_q != 2'd0) && !Stall && !PCSrc;

    case (state_q)
      S_IDLE: if (IMemReq && !IMemAck) state_d = S_WAIT;
      S_WAIT: begin
        if (IMemAck) begin
          state_d = S_IDLE;
        end else if (PCSrc) begin
          state_d     = S_DROP;
          drop_addr_d = fetch_pc_q;
        end
      end
      S_DROP: if (IMemAck) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (PCSrc)    fetch_pc_d = target;
    else if (acc) fetch_pc_d = fetch_pc_q + 32'd4;

    if (PCSrc) begin
      cnt_d    = 2'd0;
      instr0_d = NOP;
    end else begin
      case ({acc, deq})
        2'b11: begin
          if (cnt_q == 2'd2) begin
            instr0_d = instr1_q;
            pc0_d    = pc1_q;
            instr1_d = IMemRData;
            pc1_d    = fetch_pc_q;
          end else begin
            instr0_d = IMemRData;
            pc0_d    = fetch_pc_q;
          end
        end
        2'b10: begin
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd0) begin
            instr0_d = IMemRData;
            pc0_d    = fetch_pc_q;
          end else begin
            instr1_d = IMemRData;
            pc1_d    = fetch_pc_q;
          end
        end
        2'b01: begin
          cnt_d = cnt_q - 2'd1;
          // An emptied head shows NOP but keeps the last PC for the extender.
          if (cnt_q == 2'd2) begin
            instr0_d = instr1_q;
            pc0_d    = pc1_q;
          end else begin
            instr0_d = NOP;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      fetch_pc_q  <= RESET_PC;
      drop_addr_q <= RESET_PC;
      cnt_q       <= 2'd0;
      instr0_q    <= NOP;
      pc0_q       <= RESET_PC;
      instr1_q    <= NOP;
      pc1_q       <= RESET_PC;
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      drop_addr_q <= drop_addr_d;
      cnt_q       <= cnt_d;
      instr0_q    <= instr0_d;
      pc0_q       <= pc0_d;
      instr1_q    <= instr1_d;
      pc1_q       <= pc1_d;
    end
  end

  assign Instr      = instr0_q;
  assign PC         = pc0_q;
  assign PCPlus4    = pc0_q + 32'd4;
  assign InstrValid = (cnt_q != 2'd0);

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: memory model with programmable wait states and a
// scoreboard of intended PC order, popped whenever decode consumes an instruction.
module tb_instr_fetch;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset, PCSrc, Stall, IMemReq, IMemAck, InstrValid;
  logic [31:0] PCTarget, IMemAddr, IMemRData, Instr, PC, PCPlus4;

  logic        auto, man_ack;
  int          k, wcnt;
  int          n_chk = 0, n_fail = 0;
  logic [31:0] sb[$];

  instr_fetch #(.RESET_PC(32'h0)) dut (
    .clk(clk), .reset(reset), .PCSrc(PCSrc), .PCTarget(PCTarget), .Stall(Stall),
    .IMemReq(IMemReq), .IMemAddr(IMemAddr), .IMemAck(IMemAck), .IMemRData(IMemRData),
    .Instr(Instr), .PC(PC), .PCPlus4(PCPlus4), .InstrValid(InstrValid)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memdata(input logic [31:0] a);
    return a ^ 32'hA5A5_0003;
  endfunction

  assign IMemRData = memdata(IMemAddr);
  assign IMemAck   = reset ? 1'b0 : (auto ? (IMemReq && (wcnt >= k)) : man_ack);

  always @(posedge clk) begin
    if (IMemReq && !IMemAck) wcnt <= wcnt + 1;
    else                     wcnt <= 0;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic sb_load(input logic [31:0] base);
    sb.delete();
    for (int i = 0; i < 64; i++) sb.push_back(base + 32'(4 * i));
  endtask

  task automatic drive_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [31:0] base);
    drive_edge();
    reset = 1'b1; Stall = 1'b0; PCSrc = 1'b0; auto = 1'b1; man_ack = 1'b0;
    drive_edge();
    sb_load(base);
    reset = 1'b0;
  endtask

  // Decode consumes the head at the edge after a negedge with valid, no stall, no redirect.
  always @(negedge clk) begin
    if (!reset && InstrValid && !Stall && !PCSrc) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $error("FAIL sb_unexpected: observed pc %h expected none", PC);
      end else begin
        logic [31:0] e;
        e = sb.pop_front();
        check("sb_pc", PC, e);
        check("sb_instr", Instr, memdata(e));
      end
    end
  end

  initial begin
    reset = 1'b1; Stall = 1'b0; PCSrc = 1'b0; PCTarget = 32'h0;
    auto = 1'b1; man_ack = 1'b0; k = 0; wcnt = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_req", {31'd0, IMemReq}, 32'd0);
    check("rst_valid", {31'd0, InstrValid}, 32'd0);
    check("rst_instr", Instr, NOP);
    check("rst_pc", PC, 32'h0);
    check("rst_pcp4", PCPlus4, 32'h4);

    // Zero-wait streaming
    k = 0;
    sb_load(32'h0);
    reset = 1'b0;
    @(negedge clk);
    check("s_addr0", IMemAddr, 32'h0);
    check("s_valid0", {31'd0, InstrValid}, 32'd0);
    for (int i = 1; i < 4; i++) begin
      @(negedge clk);
      check("s_addr", IMemAddr, 32'(4 * i));
      check("s_valid", {31'd0, InstrValid}, 32'd1);
      check("s_pc", PC, 32'(4 * (i - 1)));
      check("s_pcp4", PCPlus4, 32'(4 * i));
    end
    repeat (4) @(negedge clk);

    // Three wait states
    k = 3;
    do_reset(32'h0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("w_req", {31'd0, IMemReq}, 32'd1);
      check("w_addr", IMemAddr, 32'h0);
    end
    @(negedge clk);
    check("w_addr4", IMemAddr, 32'h4);
    check("w_pc0", PC, 32'h0);
    @(negedge clk);
    check("w_empty_valid", {31'd0, InstrValid}, 32'd0);
    check("w_empty_instr", Instr, NOP);
    check("w_empty_pc", PC, 32'h0);
    repeat (2) @(negedge clk);
    @(negedge clk);
    check("w_pc4", PC, 32'h4);
    check("w_valid4", {31'd0, InstrValid}, 32'd1);
    repeat (6) @(negedge clk);

    // Stall backpressure, with a spurious ack while idle and full
    k = 0;
    do_reset(32'h0);
    drive_edge();
    Stall = 1'b1;
    @(negedge clk);
    check("b_req_c1", {31'd0, IMemReq}, 32'd1);
    for (int i = 2; i < 6; i++) begin
      drive_edge();
      if (i == 3) begin auto = 1'b0; man_ack = 1'b1; end
      if (i == 4) begin auto = 1'b1; man_ack = 1'b0; end
      @(negedge clk);
      check("b_req_full", {31'd0, IMemReq}, 32'd0);
      check("b_pc_frozen", PC, 32'h0);
      check("b_instr_frozen", Instr, memdata(32'h0));
    end
    drive_edge();
    Stall = 1'b0;
    repeat (6) @(negedge clk);
    check("b_pc_resume", PC, 32'h14);

    // Redirect with a request outstanding
    k = 0;
    do_reset(32'h0);
    drive_edge();
    drive_edge();
    auto = 1'b0; man_ack = 1'b0;
    @(negedge clk);
    check("r_addr8", IMemAddr, 32'h8);
    drive_edge();
    sb_load(32'h100);
    PCSrc = 1'b1; PCTarget = 32'h103;
    @(negedge clk);
    check("r_req_c3", {31'd0, IMemReq}, 32'd1);
    check("r_addr_c3", IMemAddr, 32'h8);
    for (int i = 4; i < 6; i++) begin
      drive_edge();
      PCSrc = 1'b0;
      if (i == 5) man_ack = 1'b1;
      @(negedge clk);
      check("r_drop_req", {31'd0, IMemReq}, 32'd1);
      check("r_drop_addr", IMemAddr, 32'h8);
      check("r_drop_valid", {31'd0, InstrValid}, 32'd0);
    end
    drive_edge();
    man_ack = 1'b0; auto = 1'b1;
    @(negedge clk);
    check("r_addr_tgt", IMemAddr, 32'h100);
    check("r_valid_tgt", {31'd0, InstrValid}, 32'd0);
    @(negedge clk);
    check("r_pc_tgt", PC, 32'h100);
    check("r_instr_tgt", Instr, memdata(32'h100));
    repeat (3) @(negedge clk);

    // Redirect + stall + ack together, and FetchPC wrap
    k = 1;
    do_reset(32'h0);
    drive_edge();
    drive_edge();
    Stall = 1'b1;
    drive_edge();
    sb_load(32'hFFFF_FFFC);
    PCSrc = 1'b1; PCTarget = 32'hFFFF_FFFC;
    @(negedge clk);
    check("x_ack", {31'd0, IMemAck}, 32'd1);
    drive_edge();
    PCSrc = 1'b0; Stall = 1'b0;
    @(negedge clk);
    check("x_req", {31'd0, IMemReq}, 32'd1);
    check("x_addr", IMemAddr, 32'hFFFF_FFFC);
    check("x_valid", {31'd0, InstrValid}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    check("x_pc_top", PC, 32'hFFFF_FFFC);
    check("x_pcp4_wrap", PCPlus4, 32'h0);
    check("x_addr_wrap", IMemAddr, 32'h0);
    @(negedge clk);
    check("x_empty_pc", PC, 32'hFFFF_FFFC);
    drive_edge();
    sb_load(32'h40);
    PCSrc = 1'b1; PCTarget = 32'h40;
    @(negedge clk);
    check("x_pcsrc_kills_req", {31'd0, IMemReq}, 32'd0);
    check("x_head_pc0", PC, 32'h0);
    drive_edge();
    PCSrc = 1'b0;
    @(negedge clk);
    check("x_addr40", IMemAddr, 32'h40);
    check("x_valid40", {31'd0, InstrValid}, 32'd0);
    repeat (4) @(negedge clk);

    // Asynchronous reset in the middle of a wait
    k = 0;
    do_reset(32'h0);
    drive_edge();
    auto = 1'b0; man_ack = 1'b0; Stall = 1'b1;
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check("a_req", {31'd0, IMemReq}, 32'd0);
    check("a_valid", {31'd0, InstrValid}, 32'd0);
    check("a_instr", Instr, NOP);
    check("a_pc", PC, 32'h0);
    check("a_pcp4", PCPlus4, 32'h4);
    Stall = 1'b0; auto = 1'b1;
    drive_edge();
    sb_load(32'h0);
    reset = 1'b0;
    @(negedge clk);
    check("a_addr_first", IMemAddr, 32'h0);
    check("a_req_first", {31'd0, IMemReq}, 32'd1);
    @(negedge clk);
    check("a_pc_first", PC, 32'h0);
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
